// File: rtl/aes128_encrypt_iter_pkg.sv
// Shared AES-128 definitions: round count, counter width, FSM encoding and
// the forward round transforms used by the iterative encrypt datapath.
// State byte order: byte i lives at bits [127-8*i -: 8], i = row + 4*column
// (FIPS-197 column-major, byte 0 in the top byte).
package aes128_encrypt_iter_pkg;

   localparam int unsigned AES_NR = 10;
   localparam int unsigned RCW    = $clog2(AES_NR + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_e;

   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned i = 0; i < 16; i++)
         r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
      return r;
   endfunction

   // Row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int unsigned col = 0; col < 4; col++)
         for (int unsigned row = 0; row < 4; row++)
            r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
      return r;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = '0;
      for (int unsigned col = 0; col < 4; col++) begin
         a0 = s[127-32*col -: 8];
         a1 = s[119-32*col -: 8];
         a2 = s[111-32*col -: 8];
         a3 = s[103-32*col -: 8];
         r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
      return s ^ k;
   endfunction

endpackage

// File: rtl/aes128_encrypt_iter_round.sv
// One forward AES round, purely combinational; final_round skips MixColumns.
module encrypt_round
   import aes128_encrypt_iter_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         final_round,
   output logic [127:0] state_out
);

   logic [127:0] shifted;

   // SubBytes -> ShiftRows -> optional MixColumns -> AddRoundKey
   always_comb begin
      shifted   = shift_rows(sub_bytes(state_in));
      state_out = add_round_key(final_round ? shifted : mix_columns(shifted), round_key);
   end

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one round per clock, round keys read
// combinationally from an external store addressed by rk_addr.
module aes128_encrypt_iter
   import aes128_encrypt_iter_pkg::*;
#(
   parameter int unsigned NR = AES_NR
)
(
   input  logic         clk,
   input  logic         reset,
   input  logic         pt_valid,
   output logic         pt_ready,
   input  logic [127:0] plaintext,
   output logic [3:0]   rk_addr,
   input  logic [127:0] round_key,
   output logic         ct_valid,
   input  logic         ct_ready,
   output logic [127:0] ciphertext,
   output logic         busy
);

   fsm_e           state_q, state_d;
   logic [127:0]   state_reg;
   logic [RCW-1:0] round_cnt;
   logic [127:0]   round_out;
   logic           last_round;

   // Round NR is the final round (no MixColumns) and ends in DONE
   always_comb last_round = (round_cnt == RCW'(NR));

   encrypt_round u_round (
      .state_in    (state_reg),
      .round_key   (round_key),
      .final_round (last_round),
      .state_out   (round_out)
   );

   // Next-state and output decode; ciphertext is masked outside DONE
   always_comb begin
      state_d    = state_q;
      pt_ready   = 1'b0;
      busy       = 1'b0;
      ct_valid   = 1'b0;
      ciphertext = '0;
      rk_addr    = '0;
      case (state_q)
         IDLE: begin
            pt_ready = 1'b1;
            if (pt_valid) state_d = ROUND;
         end
         ROUND: begin
            busy    = 1'b1;
            rk_addr = round_cnt;
            if (last_round) state_d = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            ct_valid   = 1'b1;
            ciphertext = state_reg;
            if (ct_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, round counter and AES state update
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         state_reg <= '0;
         round_cnt <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (pt_valid) begin
                  state_reg <= add_round_key(plaintext, round_key);
                  round_cnt <= RCW'(1);
               end
            end
            ROUND: begin
               state_reg <= round_out;
               round_cnt <= last_round ? '0 : round_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Self-checking bench for aes128_encrypt_iter: FIPS-197 vectors, latency,
// key-index sequence, backpressure, back-to-back, mid-round reset, idle
// stability and random blocks against a byte-level AES reference model.
module tb_aes128_encrypt_iter;

   typedef logic [0:15][7:0] blk_t;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk = 1'b0;
   logic         reset, pt_valid, pt_ready, ct_valid, ct_ready, busy;
   logic [127:0] plaintext, round_key, ciphertext;
   logic [3:0]   rk_addr;

   logic [127:0] rk_store [0:15];
   logic [7:0]   sbox_ref [0:255];
   int           passed = 0;
   int           total  = 0;

   always #5 clk = ~clk;

   // External round-key store: combinational read
   assign round_key = rk_store[rk_addr];

   aes128_encrypt_iter #(.NR(10)) dut (
      .clk        (clk),
      .reset      (reset),
      .pt_valid   (pt_valid),
      .pt_ready   (pt_ready),
      .plaintext  (plaintext),
      .rk_addr    (rk_addr),
      .round_key  (round_key),
      .ct_valid   (ct_valid),
      .ct_ready   (ct_ready),
      .ciphertext (ciphertext),
      .busy       (busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      logic [7:0] y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      return (b << k) | (b >> (8 - k));
   endfunction

   // S-box from multiplicative inverse (a^254) followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         if (a != 0) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
         end
         sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         rk_store[r] = '0;
         if (r <= 10) rk_store[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
      blk_t       s, t;
      logic [7:0] acc;
      logic [7:0] coef [0:3];
      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      s = pt ^ rk_store[0];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_ref[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++) begin
                  acc = 8'h00;
                  for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k-r+4)%4], t[k+4*c]);
                  s[r+4*c] = acc;
               end
         end else begin
            s = t;
         end
         s = s ^ rk_store[rnd];
      end
      return s;
   endfunction

   // ---------------- drivers ----------------
   // Raise pt_valid and return in the accepting cycle (phase: posedge+1)
   task automatic offer(input logic [127:0] pt, output bit ok);
      plaintext = pt;
      pt_valid  = 1'b1;
      ok        = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (pt_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   // From the accepting cycle, step until ct_valid; report latency and key indices
   task automatic run_to_done(input bit keep_valid, output logic [127:0] ct,
                              output int lat, output bit rk_ok, output bit ok);
      rk_ok = (rk_addr == 4'd0);
      ok    = 1'b0;
      lat   = 0;
      ct    = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (!keep_valid) pt_valid = 1'b0;
         if (rk_addr > 4'd10) rk_ok = 1'b0;
         if (ct_valid) begin
            lat = i;
            ct  = ciphertext;
            ok  = 1'b1;
            break;
         end
         if (rk_addr != 4'(i) || pt_ready || !busy) rk_ok = 1'b0;
      end
   endtask

   task automatic release_ct();
      ct_ready = 1'b1;
      @(posedge clk); #1;
      ct_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; pt_valid = 1'b0; ct_ready = 1'b0; plaintext = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      total++; if (pt_ready !== 1'b1) $display("FAIL reset_pt_ready: got %b expected 1", pt_ready); else passed++;
      total++; if (ct_valid !== 1'b0) $display("FAIL reset_ct_valid: got %b expected 0", ct_valid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
      total++; if (rk_addr !== 4'd0) $display("FAIL reset_rk_addr: got %0d expected 0", rk_addr); else passed++;
      total++; if (ciphertext !== 128'h0) $display("FAIL reset_ciphertext: got %h expected 0", ciphertext); else passed++;
   endtask

   task automatic test_vector(input string name, input logic [127:0] key,
                              input logic [127:0] pt, input logic [127:0] ct_exp);
      logic [127:0] ct;
      int lat;
      bit rk_ok, ok, acc;
      load_key(key);
      offer(pt, acc);
      run_to_done(1'b0, ct, lat, rk_ok, ok);
      total++; if (!(acc && ok)) $display("FAIL %s_timeout: accepted=%b done=%b expected 1 1", name, acc, ok); else passed++;
      total++; if (ct !== ct_exp) $display("FAIL %s_ct: got %h expected %h", name, ct, ct_exp); else passed++;
      total++; if (ct !== ref_encrypt(pt)) $display("FAIL %s_ct_model: got %h expected %h", name, ct, ref_encrypt(pt)); else passed++;
      total++; if (lat != 11) $display("FAIL %s_latency: got %0d expected 11", name, lat); else passed++;
      total++; if (!rk_ok) $display("FAIL %s_rk_seq: got bad rk_addr/busy sequence expected 0,1..10", name); else passed++;
      total++; if (pt_ready !== 1'b0 || busy !== 1'b1) $display("FAIL %s_done_flags: got pt_ready=%b busy=%b expected 0 1", name, pt_ready, busy); else passed++;
      release_ct();
      total++; if ({pt_ready, ct_valid, busy} !== 3'b100) $display("FAIL %s_to_idle: got %b expected 100", name, {pt_ready, ct_valid, busy}); else passed++;
   endtask

   task automatic test_backpressure();
      logic [127:0] ct;
      int lat;
      bit rk_ok, ok, acc;
      load_key(C1_KEY);
      offer(C1_PT, acc);
      run_to_done(1'b0, ct, lat, rk_ok, ok);
      total++; if (!(acc && ok) || ct !== C1_CT) $display("FAIL bp_ct: got %h expected %h", ct, C1_CT); else passed++;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         total++;
         if ({ct_valid, pt_ready, busy, ciphertext} !== {3'b101, C1_CT})
            $display("FAIL bp_hold[%0d]: got v=%b r=%b b=%b ct=%h expected v=1 r=0 b=1 ct=%h", i, ct_valid, pt_ready, busy, ciphertext, C1_CT);
         else passed++;
      end
      ct_ready = 1'b1;
      total++; if (pt_ready !== 1'b0) $display("FAIL bp_ready_in_hs: got %b expected 0", pt_ready); else passed++;
      @(posedge clk); #1;
      ct_ready = 1'b0;
      total++; if ({pt_ready, ct_valid, busy, ciphertext} !== {3'b100, 128'h0})
         $display("FAIL bp_release: got r=%b v=%b b=%b ct=%h expected r=1 v=0 b=0 ct=0", pt_ready, ct_valid, busy, ciphertext);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [127:0] ct1, ct2;
      int lat1, lat2;
      bit rk1, rk2, ok1, ok2, acc;
      load_key(C1_KEY);
      offer(C1_PT, acc);
      run_to_done(1'b1, ct1, lat1, rk1, ok1);
      total++; if (!(acc && ok1) || !rk1) $display("FAIL b2b_first_run: got acc=%b done=%b rk=%b expected 1 1 1", acc, ok1, rk1); else passed++;
      total++; if (ct1 !== C1_CT) $display("FAIL b2b_first_ct: got %h expected %h", ct1, C1_CT); else passed++;
      // Handshake cycle: switch the offered block and the key store
      ct_ready  = 1'b1;
      plaintext = B_PT;
      load_key(B_KEY);
      total++; if (pt_ready !== 1'b0) $display("FAIL b2b_ready_in_hs: got %b expected 0", pt_ready); else passed++;
      @(posedge clk); #1;
      ct_ready = 1'b0;
      total++; if ({pt_ready, ct_valid} !== 2'b10) $display("FAIL b2b_accept_cycle: got %b expected 10", {pt_ready, ct_valid}); else passed++;
      run_to_done(1'b0, ct2, lat2, rk2, ok2);
      total++; if (!ok2 || lat2 != 11 || !rk2) $display("FAIL b2b_second_run: got done=%b lat=%0d rk=%b expected 1 11 1", ok2, lat2, rk2); else passed++;
      total++; if (ct2 !== B_CT) $display("FAIL b2b_second_ct: got %h expected %h", ct2, B_CT); else passed++;
      release_ct();
   endtask

   task automatic test_reset_mid_round();
      logic [127:0] ct;
      int lat;
      bit rk_ok, ok, acc, seen;
      load_key(C1_KEY);
      offer(C1_PT, acc);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         pt_valid = 1'b0;
      end
      total++; if (rk_addr !== 4'd5) $display("FAIL mid_round_index: got %0d expected 5", rk_addr); else passed++;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      total++; if ({pt_ready, ct_valid, busy, rk_addr, ciphertext} !== {3'b100, 4'd0, 128'h0})
         $display("FAIL mid_reset_outputs: got r=%b v=%b b=%b a=%0d ct=%h expected 1 0 0 0 0", pt_ready, ct_valid, busy, rk_addr, ciphertext);
      else passed++;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ct_valid || busy) seen = 1'b1;
      end
      total++; if (seen) $display("FAIL mid_reset_no_ct: got activity=1 expected 0"); else passed++;
      offer(C1_PT, acc);
      run_to_done(1'b0, ct, lat, rk_ok, ok);
      total++; if (!(acc && ok) || ct !== C1_CT) $display("FAIL mid_reset_fresh_ct: got %h expected %h", ct, C1_CT); else passed++;
      release_ct();
   endtask

   task automatic test_idle();
      pt_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         total++;
         if ({pt_ready, ct_valid, busy, rk_addr, ciphertext} !== {3'b100, 4'd0, 128'h0})
            $display("FAIL idle[%0d]: got r=%b v=%b b=%b a=%0d ct=%h expected 1 0 0 0 0", i, pt_ready, ct_valid, busy, rk_addr, ciphertext);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic [127:0] key, pt, exp, ct;
      int lat;
      bit rk_ok, ok, acc;
      for (int n = 0; n < 10; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         load_key(key);
         exp = ref_encrypt(pt);
         offer(pt, acc);
         run_to_done(1'b0, ct, lat, rk_ok, ok);
         total++;
         if (!(acc && ok) || ct !== exp || lat != 11 || !rk_ok)
            $display("FAIL random[%0d]: got ct=%h lat=%0d rk=%b expected ct=%h lat=11 rk=1", n, ct, lat, rk_ok, exp);
         else passed++;
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         release_ct();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int r = 0; r < 16; r++) rk_store[r] = '0;
      build_sbox();
      test_reset();
      test_vector("c1", C1_KEY, C1_PT, C1_CT);
      test_vector("appb", B_KEY, B_PT, B_CT);
      test_backpressure();
      test_back_to_back();
      test_reset_mid_round();
      test_idle();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
